// File: rtl/lu_pkg.sv
// Shared opcode encodings and elaboration helpers for the pipelined logic unit.
package lu_pkg;

    localparam logic [3:0] LU_AND  = 4'b0000;
    localparam logic [3:0] LU_OR   = 4'b0001;
    localparam logic [3:0] LU_XOR  = 4'b0010;
    localparam logic [3:0] LU_NOR  = 4'b0011;
    localparam logic [3:0] LU_NAND = 4'b0100;
    localparam logic [3:0] LU_XNOR = 4'b0101;
    localparam logic [3:0] LU_NOTA = 4'b0110;
    localparam logic [3:0] LU_PASB = 4'b0111;
    localparam logic [3:0] LU_SLL  = 4'b1000;
    localparam logic [3:0] LU_SRL  = 4'b1001;
    localparam logic [3:0] LU_SRA  = 4'b1010;
    localparam logic [3:0] LU_ROL  = 4'b1011;
    localparam logic [3:0] LU_ROR  = 4'b1100;
    localparam logic [3:0] LU_ANDN = 4'b1101;
    localparam logic [3:0] LU_ORN  = 4'b1110;
    localparam logic [3:0] LU_CLR  = 4'b1111;

    // Number of bits needed to index 'value' positions (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lu_stage.sv
// One pipeline register slice carrying {valid, result, tag, zero, parity};
// advances only when the shared enable is high.
module lu_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             zero_i,
    input  logic             parity_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             parity_o
);

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] tag_q;
    logic             zero_q;
    logic             parity_q;

    // NOTE: data fields are reset along with valid so outputs read 0, not X, after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else if (en_i) begin
            // NOTE: non-blocking so every slice samples its neighbour's pre-edge value.
            valid_q  <= valid_i;
            result_q <= result_i;
            tag_q    <= tag_i;
            zero_q   <= zero_i;
            parity_q <= parity_i;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign tag_o    = tag_q;
    assign zero_o   = zero_q;
    assign parity_o = parity_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic/shift/rotate unit: combinational decode feeding STAGES register
// slices that all advance or stall together on one global enable.
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero,
    output logic             parity
);

    localparam int SW = clog2(WIDTH);

    logic               en;
    logic               accept;
    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] rol_full;
    logic [2*WIDTH-1:0] ror_full;
    logic [WIDTH-1:0]   result_d;

    logic               vld_q  [STAGES];
    logic [WIDTH-1:0]   res_q  [STAGES];
    logic [TAG_W-1:0]   tag_q  [STAGES];
    logic               zero_q [STAGES];
    logic               par_q  [STAGES];

    // Bubbles are never squeezed out: the whole pipe moves whenever the head can drain.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    assign shamt    = b[SW-1:0];
    assign rol_full = {a, a} << shamt;
    assign ror_full = {a, a} >> shamt;

    always_comb begin
        // NOTE: default assignment first keeps this purely combinational (no latch).
        result_d = '0;
        unique case (op)
            LU_AND:  result_d = a & b;
            LU_OR:   result_d = a | b;
            LU_XOR:  result_d = a ^ b;
            LU_NOR:  result_d = ~(a | b);
            LU_NAND: result_d = ~(a & b);
            LU_XNOR: result_d = ~(a ^ b);
            LU_NOTA: result_d = ~a;
            LU_PASB: result_d = b;
            LU_SLL:  result_d = a << shamt;
            LU_SRL:  result_d = a >> shamt;
            LU_SRA:  result_d = $signed(a) >>> shamt;
            LU_ROL:  result_d = rol_full[2*WIDTH-1:WIDTH];
            LU_ROR:  result_d = ror_full[WIDTH-1:0];
            LU_ANDN: result_d = a & ~b;
            LU_ORN:  result_d = a | ~b;
            LU_CLR:  result_d = '0;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            lu_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .en_i     (en),
                .valid_i  (accept),
                .result_i (result_d),
                .tag_i    (tag),
                .zero_i   (result_d == '0),
                .parity_i (^result_d),
                .valid_o  (vld_q[k]),
                .result_o (res_q[k]),
                .tag_o    (tag_q[k]),
                .zero_o   (zero_q[k]),
                .parity_o (par_q[k])
            );
        end else begin : g_tail
            lu_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .en_i     (en),
                .valid_i  (vld_q[k-1]),
                .result_i (res_q[k-1]),
                .tag_i    (tag_q[k-1]),
                .zero_i   (zero_q[k-1]),
                .parity_i (par_q[k-1]),
                .valid_o  (vld_q[k]),
                .result_o (res_q[k]),
                .tag_o    (tag_q[k]),
                .zero_o   (zero_q[k]),
                .parity_o (par_q[k])
            );
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out       = res_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign parity    = par_q[STAGES-1];

endmodule
